// File: rtl/gcn_operand_server.sv
// gcn_operand_server: weight/feature/COO operand store for the GCN core.
// Contents stream in once over a valid/ready port, then reads are served with 1-cycle latency.
module gcn_operand_server #(
    parameter int FEATURE_ROWS    = 6,
    parameter int FEATURE_COLS    = 96,
    parameter int WEIGHT_ROWS     = 96,
    parameter int WEIGHT_COLS     = 3,
    parameter int DATA_WIDTH      = 5,
    parameter int ADDRESS_WIDTH   = 13,
    parameter int FEATURE_BASE    = 512,
    parameter int COO_NUM_OF_ROWS = 2,
    parameter int COO_NUM_OF_COLS = 6,
    parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                load_start,
    input  logic                                load_valid,
    output logic                                load_ready,
    input  logic [DATA_WIDTH-1:0]               load_data,
    output logic                                mem_ready,
    input  logic                                enable_read,
    input  logic [ADDRESS_WIDTH-1:0]            read_address,
    output logic [WEIGHT_ROWS*DATA_WIDTH-1:0]   data_in,
    output logic                                data_valid,
    output logic                                rd_error,
    input  logic [COO_BW-1:0]                   coo_address,
    output logic [COO_NUM_OF_ROWS*COO_BW-1:0]   coo_in
);

    localparam int DW      = DATA_WIDTH;
    localparam int RDW     = WEIGHT_ROWS * DW;
    localparam int RW      = $clog2(WEIGHT_ROWS);
    localparam int WCW     = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
    localparam int FRW     = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
    localparam int CRW     = (COO_NUM_OF_ROWS > 1) ? $clog2(COO_NUM_OF_ROWS) : 1;
    localparam int MIN_MAX = (WEIGHT_ROWS > COO_NUM_OF_COLS) ? WEIGHT_ROWS : COO_NUM_OF_COLS;
    localparam int MAJ_A   = (WEIGHT_COLS > FEATURE_ROWS) ? WEIGHT_COLS : FEATURE_ROWS;
    localparam int MAJ_MAX = (MAJ_A > COO_NUM_OF_ROWS) ? MAJ_A : COO_NUM_OF_ROWS;
    localparam int MINW    = (MIN_MAX > 1) ? $clog2(MIN_MAX) : 1;
    localparam int MAJW    = (MAJ_MAX > 1) ? $clog2(MAJ_MAX) : 1;

    typedef enum logic [2:0] {EMPTY, LOAD_W, LOAD_F, LOAD_C, READY} state_e;

    state_e                  state_q, state_d;
    logic [MINW-1:0]         minor_q, minor_d;
    logic [MAJW-1:0]         major_q, major_d;
    logic                    mem_ready_q, mem_ready_d;
    logic [RDW-1:0]          data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic [COO_NUM_OF_ROWS*COO_BW-1:0] coo_q, coo_d;

    logic [DW-1:0]     w_mem [WEIGHT_COLS][WEIGHT_ROWS];
    logic [DW-1:0]     f_mem [FEATURE_ROWS][FEATURE_COLS];
    logic [COO_BW-1:0] c_mem [COO_NUM_OF_ROWS][COO_NUM_OF_COLS];

    logic accept, minor_last, major_last;
    logic is_w, is_f, serve;
    logic [ADDRESS_WIDTH-1:0] f_off;
    logic [RDW-1:0] w_row, f_row;
    logic [COO_NUM_OF_ROWS*COO_BW-1:0] c_col;

    assign load_ready = state_q inside {LOAD_W, LOAD_F, LOAD_C};
    assign accept     = load_valid && load_ready && !load_start;

    always_comb begin
        minor_last = 1'b0;
        major_last = 1'b0;
        unique case (state_q)
            LOAD_W: begin
                minor_last = (minor_q == MINW'(WEIGHT_ROWS - 1));
                major_last = (major_q == MAJW'(WEIGHT_COLS - 1));
            end
            LOAD_F: begin
                minor_last = (minor_q == MINW'(FEATURE_COLS - 1));
                major_last = (major_q == MAJW'(FEATURE_ROWS - 1));
            end
            LOAD_C: begin
                minor_last = (minor_q == MINW'(COO_NUM_OF_COLS - 1));
                major_last = (major_q == MAJW'(COO_NUM_OF_ROWS - 1));
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        minor_d     = minor_q;
        major_d     = major_q;
        mem_ready_d = (state_q == READY) && !load_start;
        if (load_start) begin
            state_d = LOAD_W;
            minor_d = '0;
            major_d = '0;
        end else if (accept) begin
            if (!minor_last) begin
                minor_d = minor_q + MINW'(1);
            end else begin
                minor_d = '0;
                if (!major_last) begin
                    major_d = major_q + MAJW'(1);
                end else begin
                    major_d = '0;
                    unique case (state_q)
                        LOAD_W:  state_d = LOAD_F;
                        LOAD_F:  state_d = LOAD_C;
                        default: state_d = READY;
                    endcase
                end
            end
        end
    end

    // Storage is never cleared; the FSM alone decides whether it is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            unique case (state_q)
                LOAD_W: w_mem[major_q[WCW-1:0]][minor_q[RW-1:0]] <= load_data;
                LOAD_F: f_mem[major_q[FRW-1:0]][minor_q[RW-1:0]] <= load_data;
                LOAD_C: c_mem[major_q[CRW-1:0]][minor_q[COO_BW-1:0]] <= load_data[COO_BW-1:0];
                default: ;
            endcase
        end
    end

    assign serve = (state_q == READY);
    assign f_off = read_address - ADDRESS_WIDTH'(FEATURE_BASE);
    assign is_w  = read_address < ADDRESS_WIDTH'(WEIGHT_COLS);
    assign is_f  = (read_address >= ADDRESS_WIDTH'(FEATURE_BASE))
                && (f_off < ADDRESS_WIDTH'(FEATURE_ROWS));

    for (genvar g = 0; g < WEIGHT_ROWS; g++) begin : g_pack
        assign w_row[(WEIGHT_ROWS-1-g)*DW +: DW] = w_mem[read_address[WCW-1:0]][g];
        assign f_row[(WEIGHT_ROWS-1-g)*DW +: DW] = f_mem[f_off[FRW-1:0]][g];
    end

    for (genvar r = 0; r < COO_NUM_OF_ROWS; r++) begin : g_coo
        assign c_col[(COO_NUM_OF_ROWS-1-r)*COO_BW +: COO_BW] = c_mem[r][coo_address];
    end

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (enable_read) begin
            if (serve && is_w) begin
                data_d  = w_row;
                valid_d = 1'b1;
            end else if (serve && is_f) begin
                data_d  = f_row;
                valid_d = 1'b1;
            end else begin
                data_d = '0;
                err_d  = 1'b1;
            end
        end
        coo_d = '0;
        if (serve && (coo_address < COO_BW'(COO_NUM_OF_COLS))) begin
            coo_d = c_col;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            minor_q     <= '0;
            major_q     <= '0;
            mem_ready_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            coo_q       <= '0;
        end else begin
            state_q     <= state_d;
            minor_q     <= minor_d;
            major_q     <= major_d;
            mem_ready_q <= mem_ready_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            coo_q       <= coo_d;
        end
    end

    assign mem_ready  = mem_ready_q;
    assign data_in    = data_q;
    assign data_valid = valid_q;
    assign rd_error   = err_q;
    assign coo_in     = coo_q;

endmodule

// File: tb/tb_gcn_operand_server.sv
// tb_gcn_operand_server: scoreboard bench for the GCN operand server.
// Read responses are queued at issue time and checked by an independent monitor.
module tb_gcn_operand_server;

    localparam int NW    = 3;
    localparam int NR    = 96;
    localparam int NF    = 6;
    localparam int DW    = 5;
    localparam int AW    = 13;
    localparam int CB    = 3;
    localparam int NC    = 6;
    localparam int RDW   = NR * DW;
    localparam int TOTAL = NW*NR + NF*NR + 2*NC;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load_start = 1'b0;
    logic load_valid = 1'b0;
    logic enable_read = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic [AW-1:0] read_address = '0;
    logic [CB-1:0] coo_address = '0;
    logic load_ready, mem_ready, data_valid, rd_error;
    logic [RDW-1:0] data_in;
    logic [2*CB-1:0] coo_in;

    gcn_operand_server dut (
        .clk(clk), .reset(reset),
        .load_start(load_start), .load_valid(load_valid),
        .load_ready(load_ready), .load_data(load_data),
        .mem_ready(mem_ready), .enable_read(enable_read),
        .read_address(read_address), .data_in(data_in),
        .data_valid(data_valid), .rd_error(rd_error),
        .coo_address(coo_address), .coo_in(coo_in)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] wm [NW][NR];
    logic [DW-1:0] fm [NF][NR];
    logic [CB-1:0] cm [2][NC];
    logic [DW-1:0] stream [TOTAL];
    bit model_ready = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        string nm;
        logic [RDW+1:0] rsp;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic void fill(input int s);
        for (int c = 0; c < NW; c++)
            for (int r = 0; r < NR; r++) wm[c][r] = DW'(c*7 + r*3 + s);
        for (int r = 0; r < NF; r++)
            for (int c = 0; c < NR; c++) fm[r][c] = DW'(r*5 + c + 2*s);
        for (int i = 0; i < NC; i++) begin
            cm[0][i] = CB'(i);
            cm[1][i] = CB'((i + 1) % NC);
        end
    endfunction

    function automatic void build();
        int k;
        k = 0;
        for (int c = 0; c < NW; c++)
            for (int r = 0; r < NR; r++) begin stream[k] = wm[c][r]; k++; end
        for (int r = 0; r < NF; r++)
            for (int c = 0; c < NR; c++) begin stream[k] = fm[r][c]; k++; end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NC; c++) begin stream[k] = DW'(cm[r][c]); k++; end
    endfunction

    function automatic logic [RDW-1:0] pack_w(input int c);
        logic [RDW-1:0] v;
        for (int i = 0; i < NR; i++) v[(NR-1-i)*DW +: DW] = wm[c][i];
        return v;
    endfunction

    function automatic logic [RDW-1:0] pack_f(input int r);
        logic [RDW-1:0] v;
        for (int i = 0; i < NR; i++) v[(NR-1-i)*DW +: DW] = fm[r][i];
        return v;
    endfunction

    function automatic logic [RDW+1:0] expect_rd(input int a);
        if (model_ready && a < NW) return {2'b10, pack_w(a)};
        if (model_ready && a >= 512 && a < 512 + NF) return {2'b10, pack_f(a - 512)};
        return {2'b01, {RDW{1'b0}}};
    endfunction

    always @(negedge clk) begin
        if (!reset && (data_valid || rd_error)) begin
            if (sb.size() == 0) begin
                chk("sb_spurious", {data_valid, rd_error, data_in}, '0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk(e.nm, {data_valid, rd_error, data_in}, e.rsp);
            end
        end
    end

    task automatic rd(input int a, input string nm);
        exp_t e;
        enable_read  = 1'b1;
        read_address = AW'(a);
        e.nm  = nm;
        e.rsp = expect_rd(a);
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 5'h1B;
        @(posedge clk); #1;
        load_start = 1'b0;
        load_valid = 1'b0;
        model_ready = 1'b0;
    endtask

    task automatic feed(input int from, input int to, input bit toggle);
        int idx;
        int cyc;
        bit v;
        bit acc;
        idx = from;
        cyc = 0;
        v = 1'b1;
        while (idx < to && cyc < 4000) begin
            load_valid = v;
            load_data  = stream[idx];
            acc = v && load_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
            if (toggle) v = !v;
        end
        load_valid = 1'b0;
        chk("feed_count", idx, to);
    endtask

    task automatic finish_load(input string nm);
        chk({nm, "_lr_drop"}, load_ready, 1'b0);
        chk({nm, "_mr_early"}, mem_ready, 1'b0);
        @(posedge clk); #1;
        chk({nm, "_mr_rise"}, mem_ready, 1'b1);
        model_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        fill(1);
        wm[1][0] = 5'b10101;
        for (int c = 0; c < NR; c++) fm[1][c] = 5'h1F;
        build();

        #12;
        chk("rst_mem_ready", mem_ready, 1'b0);
        chk("rst_load_ready", load_ready, 1'b0);
        chk("rst_data_valid", data_valid, 1'b0);
        chk("rst_rd_error", rd_error, 1'b0);
        chk("rst_data_in", data_in, '0);
        chk("rst_coo_in", coo_in, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        rd(0, "rd_empty");
        enable_read = 1'b0;
        coo_address = 3'd3;
        @(posedge clk); #1;
        chk("coo_empty", coo_in, '0);

        start_load();
        chk("lr_in_load", load_ready, 1'b1);
        feed(0, TOTAL, 1'b0);
        finish_load("ld1");

        rd(1, "rd_w1");
        chk("w1_e0", data_in[479:475], 5'b10101);
        rd(513, "rd_f1");
        chk("f1_ones", data_in, {RDW{1'b1}});
        rd(518, "rd_oor518");
        chk("oor_data", data_in, '0);
        rd(0, "rd_w0");
        rd(2, "rd_w2");
        rd(512, "rd_f0");
        rd(3, "rd_oor3");
        rd(511, "rd_oor511");
        rd(517, "rd_f5");
        enable_read = 1'b0;
        @(posedge clk); #1;
        chk("hold_data", data_in, pack_f(5));
        chk("hold_valid", data_valid, 1'b0);

        coo_address = 3'd3;
        @(posedge clk); #1;
        chk("coo3", coo_in, 6'b011_100);
        coo_address = 3'd5;
        @(posedge clk); #1;
        chk("coo5", coo_in, 6'b101_000);
        coo_address = 3'd6;
        @(posedge clk); #1;
        chk("coo6", coo_in, '0);
        coo_address = 3'd0;
        @(posedge clk); #1;
        chk("coo0", coo_in, 6'b000_001);

        fill(2);
        build();
        start_load();
        chk("mr_drop", mem_ready, 1'b0);
        rd(0, "rd_after_start");
        enable_read = 1'b0;
        feed(0, 100, 1'b1);
        rd(0, "rd_loading");
        enable_read = 1'b0;
        feed(100, TOTAL, 1'b1);
        finish_load("ld2");
        rd(0, "rd_new_w0");
        rd(514, "rd_new_f2");
        enable_read = 1'b0;
        @(posedge clk); #1;

        fill(3);
        build();
        start_load();
        feed(0, 400, 1'b0);
        enable_read  = 1'b1;
        read_address = '0;
        @(posedge clk); #1;
        chk("pend_err", rd_error, 1'b1);
        reset = 1'b1;
        #1;
        chk("arst_data_valid", data_valid, 1'b0);
        chk("arst_rd_error", rd_error, 1'b0);
        chk("arst_mem_ready", mem_ready, 1'b0);
        chk("arst_load_ready", load_ready, 1'b0);
        chk("arst_data_in", data_in, '0);
        enable_read = 1'b0;
        model_ready = 1'b0;
        #3;
        reset = 1'b0;
        @(posedge clk); #1;

        start_load();
        feed(0, TOTAL, 1'b0);
        finish_load("ld3");
        rd(2, "rd3_w2");
        rd(515, "rd3_f3");
        enable_read = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
